scan_code_gen: RTL and testbench
================================

# scan_code_gen

Sequential code generator that drives the 4-bit select input of the downstream 3-to-8 one-hot decoder. It steps through up to eight slots (code 4'b1sss, with the MSB acting as the decoder enable), holds each slot for a programmable dwell time, and skips masked slots. It presents 4'b0000, which blanks all decoder outputs, whenever it is idle. Typical use is a digit/LED scan or row-strobe sequencer feeding the decoder.

## Interface
- DWELL, 1000: clock cycles each slot is held; legal range 2..65535.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low forces idle.
- mode  in  1  0 = continuous scan, 1 = single sweep on start.
- start  in  1  single-cycle pulse that begins a sweep when mode=1; ignored when busy.
- mask  in  8  bit i=1 enables slot i.
- code  out  4  to decoder A[3:0]; {1'b1, slot[2:0]} when active, 4'b0000 when idle or blank.
- slot_stb  out  1  one-cycle pulse in the first cycle a new slot code is presented.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a single sweep.

## Operation
- Reset values: code=4'b0000, slot_stb=0, busy=0, done=0, state=IDLE, slot index=0, dwell counter=0.
- States: IDLE, DWELL, plus BLANK when SCAN_BLANK_EN is defined.
- IDLE to DWELL:
  - mode=0: when en=1 and mask!=0.
  - mode=1: when en=1, start=1 and mask!=0.
  - The first slot is the lowest set bit of mask. mode is latched on this transition.
- Single-sweep start with mask==0: no slot is presented; done pulses on the next cycle; busy stays 0.
- DWELL: code={1,idx}. The counter runs DWELL cycles. On expiry the next slot is chosen as the lowest set bit of mask above idx.
  - Continuous mode: if no set bit exists above idx, wrap to the lowest set bit.
  - Single mode: if no set bit exists above idx, go to IDLE with code=0, busy=0 and done=1.
- Only one slot enabled in continuous mode: code stays constant and slot_stb re-pulses every DWELL cycles.
- mask is sampled only when the next slot is chosen. Changing mask mid-dwell, including masking the current slot, does not shorten the current dwell.
- Continuous mode, mask becomes 0 at the advance point: go to IDLE, code=0, no done.
- en deasserted in any state: next cycle IDLE, code=0, busy=0, no done pulse. The counter and index are cleared.
- start while busy: ignored. mode changes while busy: ignored until the next IDLE exit.
- rst_n asserted mid-operation: all outputs return to reset values immediately (asynchronous).

## Timing
- All outputs are registered.
- Start/en qualifying edge at cycle t: code and slot_stb are valid at t+1.
- Each slot code is held for exactly DWELL cycles, t+1..t+DWELL. The following code appears at t+DWELL+1, with slot_stb high.
- Without blanking, the slot period is DWELL and there are no gap cycles between slots.
- done coincides with the first cycle in which code=0 after the last slot.
- Minimum cycles from done to an accepted new start: 1 (start is sampled in the cycle done is high).

## Configuration
- SCAN_BLANK_EN defined:
  - One BLANK cycle (code=4'b0000, busy=1) is inserted after every slot dwell, including the continuous-mode wrap.
  - The slot period becomes DWELL+1.
  - On a single-sweep end, the design goes directly to IDLE with no extra blank cycle.
- SCAN_BLANK_EN undefined: no BLANK state; consecutive slots are back-to-back.

## Structure
- Package scan_pkg contains:
  - the state enum (IDLE, DWELL, BLANK);
  - CODE_BLANK = 4'b0000;
  - CODE_EN_BIT = 3;
  - counter width DWELL_W = 16.
- Sub-module slot_next_finder: purely combinational.
  - Inputs: mask[7:0], idx[2:0].
  - Outputs: found_above, next_above[2:0], lowest[2:0], any.
- Top level contains the FSM, dwell counter and output registers.

## Test plan
- Continuous run, DWELL=4, mask=8'hFF, en=1: code 8,9,...,15,8 with each value held 4 cycles; slot_stb every 4 cycles; busy=1; done never pulses.
- Single sweep, mask=8'b1010_0100, start pulse at cycle t: code 4'hA at t+1..t+4, 4'hD at t+5..t+8, 4'hF at t+9..t+12; at t+13 code=0, done=1, busy=0.
- Skip/mask change: continuous run with mask=8'h03; at mid-dwell of slot 0, set mask=8'h02. Slot 0 completes its 4 cycles, then only code 9 repeats with slot_stb every 4 cycles.
- Abort: en dropped mid-dwell of slot 3. Next cycle code=0, busy=0, done=0. Reasserting en restarts at the lowest enabled slot. Asserting rst_n=0 asynchronously clears all outputs.
- Edge cases:
  - start with mask=0: done pulses once, busy stays 0.
  - start while busy: ignored.
  - DWELL=2: each code is held exactly 2 cycles.
- SCAN_BLANK_EN build, DWELL=4, mask=8'h03, continuous: 8 for 4 cycles, 0 for 1, 9 for 4, 0 for 1, 8 again; period 5 cycles per slot.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the scan code generator.
// Holds the FSM state enum, decoder code constants and the slot priority helper.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    BLANK
  } state_t;

  localparam logic [3:0] CODE_BLANK  = 4'b0000;
  localparam int         CODE_EN_BIT = 3;
  localparam int         DWELL_W     = 16;

  // Index of the lowest set bit; 0 when no bit is set (callers qualify with |m).
  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/slot_next_finder.sv
// Combinational slot picker: the next enabled slot above idx and the lowest enabled slot.
// No latency; pure function of mask and idx.
module slot_next_finder
  import scan_pkg::*;
(
  input  logic [7:0] mask,
  input  logic [2:0] idx,
  output logic       found_above,
  output logic [2:0] next_above,
  output logic [2:0] lowest,
  output logic       any
);

  logic [7:0] above;

  // Clear bits 0..idx; at idx=7 the shift overflows to zero and the mask clears entirely.
  assign above       = mask & ~((8'd2 << idx) - 8'd1);
  assign found_above = |above;
  assign next_above  = lowest_bit(above);
  assign lowest      = lowest_bit(mask);
  assign any         = |mask;

endmodule

// File: rtl/scan_code_gen.sv
// Sequential 3-to-8 decoder select generator: steps enabled slots, holding each for DWELL cycles.
// Optional SCAN_BLANK_EN inserts one blank (code 0) cycle after every slot dwell.
module scan_code_gen
  import scan_pkg::*;
#(
  parameter int DWELL = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  input  logic       start,
  input  logic [7:0] mask,
  output logic [3:0] code,
  output logic       slot_stb,
  output logic       busy,
  output logic       done
);

  localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

  state_t             state;
  logic [2:0]         idx;
  logic [DWELL_W-1:0] cnt;
  logic               mode_q;

  logic               found_above;
  logic               any;
  logic [2:0]         next_above;
  logic [2:0]         lowest;
  logic               adv_ok;
  logic [2:0]         adv_idx;

  slot_next_finder u_find (
    .mask        (mask),
    .idx         (idx),
    .found_above (found_above),
    .next_above  (next_above),
    .lowest      (lowest),
    .any         (any)
  );

  // Continuous mode wraps to the lowest slot; single mode ends when nothing lies above.
  assign adv_ok  = found_above || (!mode_q && any);
  assign adv_idx = found_above ? next_above : lowest;

  function automatic logic [3:0] slot_code(input logic [2:0] s);
    logic [3:0] c;
    c              = CODE_BLANK;
    c[CODE_EN_BIT] = 1'b1;
    c[2:0]         = s;
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 3'd0;
      cnt      <= '0;
      mode_q   <= 1'b0;
      code     <= CODE_BLANK;
      slot_stb <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      slot_stb <= 1'b0;
      done     <= 1'b0;
      if (!en) begin
        state <= IDLE;
        idx   <= 3'd0;
        cnt   <= '0;
        code  <= CODE_BLANK;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if ((!mode || start) && any) begin
              state    <= scan_pkg::DWELL;
              idx      <= lowest;
              cnt      <= '0;
              code     <= slot_code(lowest);
              slot_stb <= 1'b1;
              busy     <= 1'b1;
              mode_q   <= mode;
            end else if (mode && start) begin
              done <= 1'b1;
            end
          end
          scan_pkg::DWELL: begin
            if (cnt != LAST) begin
              cnt <= cnt + 1'b1;
            end else begin
              cnt <= '0;
              if (adv_ok) begin
                idx <= adv_idx;
`ifdef SCAN_BLANK_EN
                state <= BLANK;
                code  <= CODE_BLANK;
`else
                code     <= slot_code(adv_idx);
                slot_stb <= 1'b1;
`endif
              end else begin
                state <= IDLE;
                idx   <= 3'd0;
                code  <= CODE_BLANK;
                busy  <= 1'b0;
                done  <= mode_q;
              end
            end
          end
`ifdef SCAN_BLANK_EN
          BLANK: begin
            state    <= scan_pkg::DWELL;
            cnt      <= '0;
            code     <= slot_code(idx);
            slot_stb <= 1'b1;
          end
`endif
          default: begin
            state <= IDLE;
            idx   <= 3'd0;
            cnt   <= '0;
            code  <= CODE_BLANK;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_code_gen.sv
// Directed bench for scan_code_gen (DWELL=4 main instance, DWELL=2 side instance).
// Expected sequences adapt when built with SCAN_BLANK_EN.
module tb_scan_code_gen;

`ifdef SCAN_BLANK_EN
  localparam int  P     = 5;
  localparam bit  BLANK = 1'b1;
`else
  localparam int  P     = 4;
  localparam bit  BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mask = 8'h00;

  logic [3:0] code, d2_code;
  logic       slot_stb, busy, done;
  logic       d2_stb, d2_busy, d2_done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  scan_code_gen #(.DWELL(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .start(start), .mask(mask),
    .code(code), .slot_stb(slot_stb), .busy(busy), .done(done)
  );

  scan_code_gen #(.DWELL(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .start(start), .mask(mask),
    .code(d2_code), .slot_stb(d2_stb), .busy(d2_busy), .done(d2_done)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one full slot dwell (plus the trailing blank cycle when enabled and requested).
  task automatic expect_slot(input logic [2:0] s, input bit blank_after);
    for (int c = 0; c < 4; c++) begin
      chk("slot_code", 8'(code), 8'({1'b1, s}));
      chk("slot_stb", 8'(slot_stb), 8'(c == 0));
      chk("slot_busy", 8'(busy), 8'd1);
      chk("slot_done", 8'(done), 8'd0);
      tick();
      start = 1'b0;
    end
    if (BLANK && blank_after) begin
      chk("blank_code", 8'(code), 8'd0);
      chk("blank_busy", 8'(busy), 8'd1);
      chk("blank_stb", 8'(slot_stb), 8'd0);
      tick();
    end
  endtask

  logic [3:0] exp2 [6];

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_code", 8'(code), 8'd0);
    chk("rst_stb", 8'(slot_stb), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    rst_n = 1'b1;
    tick();

    // Continuous scan over all eight slots, including the wrap
    mode = 1'b0; mask = 8'hFF; en = 1'b1;
    tick();
    for (int s = 0; s < 8; s++) expect_slot(3'(s), 1'b1);
    chk("wrap_code", 8'(code), 8'h08);
    chk("wrap_stb", 8'(slot_stb), 8'd1);
    en = 1'b0;
    tick();
    chk("stop_code", 8'(code), 8'd0);
    chk("stop_busy", 8'(busy), 8'd0);

    // Single sweep over slots 2,5,7; start and mode change while busy are ignored
    mode = 1'b1; mask = 8'b1010_0100; en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    expect_slot(3'd2, 1'b1);
    mode = 1'b0; start = 1'b1;
    expect_slot(3'd5, 1'b1);
    mode = 1'b1;
    expect_slot(3'd7, 1'b0);
    chk("sweep_end_code", 8'(code), 8'd0);
    chk("sweep_end_done", 8'(done), 8'd1);
    chk("sweep_end_busy", 8'(busy), 8'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_code", 8'(code), 8'h0A);
    chk("restart_stb", 8'(slot_stb), 8'd1);
    chk("restart_done", 8'(done), 8'd0);
    en = 1'b0;
    tick();

    // Mask change mid-dwell of slot 0
    mode = 1'b0; mask = 8'h03; en = 1'b1;
    tick();
    chk("mc_code0", 8'(code), 8'h08);
    chk("mc_stb0", 8'(slot_stb), 8'd1);
    tick();
    mask = 8'h02;
    for (int c = 1; c < 4; c++) begin
      chk("mc_hold", 8'(code), 8'h08);
      chk("mc_hold_stb", 8'(slot_stb), 8'd0);
      tick();
    end
    if (BLANK) begin
      chk("mc_blank", 8'(code), 8'd0);
      tick();
    end
    expect_slot(3'd1, 1'b1);
    expect_slot(3'd1, 1'b1);
    chk("mc_repeat_code", 8'(code), 8'h09);
    chk("mc_repeat_stb", 8'(slot_stb), 8'd1);
    en = 1'b0;
    tick();

    // Abort mid-dwell of slot 3, restart, then asynchronous reset
    mode = 1'b0; mask = 8'hFF; en = 1'b1;
    tick();
    repeat (3 * P + 1) tick();
    chk("abort_pre_code", 8'(code), 8'h0B);
    en = 1'b0;
    tick();
    chk("abort_code", 8'(code), 8'd0);
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_done", 8'(done), 8'd0);
    chk("abort_stb", 8'(slot_stb), 8'd0);
    en = 1'b1;
    tick();
    chk("reen_code", 8'(code), 8'h08);
    chk("reen_stb", 8'(slot_stb), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_code", 8'(code), 8'd0);
    chk("arst_busy", 8'(busy), 8'd0);
    chk("arst_stb", 8'(slot_stb), 8'd0);
    en = 1'b0;
    #2 rst_n = 1'b1;
    tick();

    // Single-sweep start with an empty mask
    mode = 1'b1; mask = 8'h00; en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_done", 8'(done), 8'd1);
    chk("empty_busy", 8'(busy), 8'd0);
    chk("empty_code", 8'(code), 8'd0);
    tick();
    chk("empty_done_once", 8'(done), 8'd0);
    chk("empty_busy_after", 8'(busy), 8'd0);
    en = 1'b0;
    tick();

    // DWELL=2 instance: continuous scan of slots 0 and 1
`ifdef SCAN_BLANK_EN
    exp2[0] = 4'h8; exp2[1] = 4'h8; exp2[2] = 4'h0;
    exp2[3] = 4'h9; exp2[4] = 4'h9; exp2[5] = 4'h0;
`else
    exp2[0] = 4'h8; exp2[1] = 4'h8; exp2[2] = 4'h9;
    exp2[3] = 4'h9; exp2[4] = 4'h8; exp2[5] = 4'h8;
`endif
    mode = 1'b0; mask = 8'h03; en = 1'b1;
    tick();
    chk("d2_stb_first", 8'(d2_stb), 8'd1);
    chk("d2_busy", 8'(d2_busy), 8'd1);
    for (int i = 0; i < 6; i++) begin
      chk("d2_code", 8'(d2_code), 8'(exp2[i]));
      chk("d2_done", 8'(d2_done), 8'd0);
      tick();
    end
    en = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
